// File: rtl/keysearch_scheduler.sv
// -----------------------------------------------------------------------------
// keysearch_scheduler
//
// Hands out contiguous chunks of the RC4 key space to NUM_CORES arcfour cores
// and stops the whole array on the first successful decryption.
//
// Ports
//   clk           in   clock; every register updates on its rising edge
//   reset         in   asynchronous, active-high; clears all state
//   start         in   one-cycle pulse that begins a fresh search
//   core_start    out  one-cycle launch pulse per core
//   core_base     out  per-core chunk base key, held until that core's next launch
//   core_abort    out  level; sends every core back to idle
//   core_done     in   per-core pulse: chunk exhausted with no hit
//   core_hit      in   per-core pulse: decryption succeeded
//   core_hit_key  in   per-core key that succeeded, valid with core_hit
//   busy          out  high while chunks are in flight (RUN / DRAIN)
//   found         out  high once a winning key has been captured
//   exhausted     out  high once the whole key space was searched with no hit
//   found_key     out  captured winning key
//   found_core    out  index of the winning core
//
// Build option
//   KEYSEARCH_RR_EN  when defined, dispatch and hit arbitration rotate through
//                    the cores with a round-robin pointer. When undefined both
//                    use fixed priority, lowest core index first.
// -----------------------------------------------------------------------------
module keysearch_scheduler #(
   parameter  int NUM_CORES = 4,
   parameter  int KEY_BITS  = 22,
   parameter  int CHUNK_LOG = 16,
   localparam int IDXW      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   output logic [NUM_CORES-1:0]          core_start,
   output logic [NUM_CORES*KEY_BITS-1:0] core_base,
   output logic                          core_abort,
   input  logic [NUM_CORES-1:0]          core_done,
   input  logic [NUM_CORES-1:0]          core_hit,
   input  logic [NUM_CORES*KEY_BITS-1:0] core_hit_key,
   output logic                          busy,
   output logic                          found,
   output logic                          exhausted,
   output logic [KEY_BITS-1:0]           found_key,
   output logic [IDXW-1:0]               found_core
);

   // One extra bit so the counter can hold NUM_CHUNKS itself without wrapping.
   localparam int CW = KEY_BITS - CHUNK_LOG + 1;
   localparam logic [CW-1:0] LAST_CHUNK = CW'(1) << (KEY_BITS - CHUNK_LOG);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_FOUND,
      S_EXHAUSTED
   } state_t;

   state_t                        state_q, state_d;
   logic [CW-1:0]                 chunk_q, chunk_d;
   logic [NUM_CORES-1:0]          active_q, active_d;   // 1 = core owns a chunk
   logic [NUM_CORES-1:0]          start_q, start_d;
   logic [NUM_CORES*KEY_BITS-1:0] base_q, base_d;
   logic                          abort_q, abort_d;
   logic                          busy_q, busy_d;
   logic                          found_q, found_d;
   logic                          exh_q, exh_d;
   logic [KEY_BITS-1:0]           fkey_q, fkey_d;
   logic [IDXW-1:0]               fcore_q, fcore_d;

   logic [IDXW-1:0]               ptr;
   logic [NUM_CORES-1:0]          done_ok, hit_ok, eligible;
   logic [IDXW:0]                 hit_pick, disp_pick;
   logic [KEY_BITS-1:0]           base_val;

   // First set bit of vec at or after ptr, wrapping. Returns {any, index}.
   function automatic logic [IDXW:0] pick_first(input logic [NUM_CORES-1:0] vec,
                                                input logic [IDXW-1:0]      p);
      logic [IDXW:0]   r;
      logic [IDXW-1:0] jj;
      int              j;
      r = '0;
      // Walk from the far end so the closest match to p is written last.
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         j = int'(p) + i;
         if (j >= NUM_CORES) j = j - NUM_CORES;
         jj = IDXW'(j);
         if (vec[jj]) r = {1'b1, jj};
      end
      return r;
   endfunction

`ifdef KEYSEARCH_RR_EN
   logic [IDXW-1:0] rr_q, rr_d;

   function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
      if (int'(i) == NUM_CORES - 1) return '0;
      return i + 1'b1;
   endfunction

   assign ptr = rr_q;
`else
   assign ptr = '0;
`endif

   // Pulses from cores that do not own a chunk are stale and ignored.
   assign done_ok   = core_done & active_q;
   assign hit_ok    = core_hit & active_q;
   assign eligible  = ~active_q | done_ok;
   assign hit_pick  = pick_first(hit_ok, ptr);
   assign disp_pick = pick_first(eligible, ptr);
   assign base_val  = KEY_BITS'(chunk_q) << CHUNK_LOG;

   always_comb begin
      state_d  = state_q;
      chunk_d  = chunk_q;
      active_d = active_q;
      start_d  = '0;
      base_d   = base_q;
      fkey_d   = fkey_q;
      fcore_d  = fcore_q;
`ifdef KEYSEARCH_RR_EN
      rr_d     = rr_q;
`endif

      case (state_q)
         S_IDLE, S_FOUND, S_EXHAUSTED: begin
            if (start) begin
               state_d  = S_RUN;
               chunk_d  = '0;
               active_d = '0;
               fkey_d   = '0;
               fcore_d  = '0;
`ifdef KEYSEARCH_RR_EN
               rr_d     = '0;
`endif
            end
         end

         S_RUN, S_DRAIN: begin
            active_d = active_q & ~done_ok;
            if (hit_pick[IDXW]) begin
               // A hit overrides any dispatch decision in the same cycle.
               state_d = S_FOUND;
               fcore_d = hit_pick[IDXW-1:0];
               fkey_d  = core_hit_key[hit_pick[IDXW-1:0]*KEY_BITS +: KEY_BITS];
            end else if (state_q == S_RUN) begin
               if (disp_pick[IDXW] && (chunk_q != LAST_CHUNK)) begin
                  start_d[disp_pick[IDXW-1:0]]                       = 1'b1;
                  base_d[disp_pick[IDXW-1:0]*KEY_BITS +: KEY_BITS]   = base_val;
                  active_d[disp_pick[IDXW-1:0]]                      = 1'b1;
                  chunk_d                                            = chunk_q + 1'b1;
`ifdef KEYSEARCH_RR_EN
                  rr_d = next_idx(disp_pick[IDXW-1:0]);
`endif
                  if (chunk_q + 1'b1 == LAST_CHUNK) state_d = S_DRAIN;
               end
            end else if (active_d == '0) begin
               state_d = S_EXHAUSTED;
            end
         end

         default: state_d = S_IDLE;
      endcase

      // Status outputs are registered copies of the state being entered.
      busy_d  = (state_d == S_RUN) || (state_d == S_DRAIN);
      found_d = (state_d == S_FOUND);
      abort_d = (state_d == S_FOUND);
      exh_d   = (state_d == S_EXHAUSTED);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         chunk_q  <= '0;
         active_q <= '0;
         start_q  <= '0;
         base_q   <= '0;
         abort_q  <= 1'b0;
         busy_q   <= 1'b0;
         found_q  <= 1'b0;
         exh_q    <= 1'b0;
         fkey_q   <= '0;
         fcore_q  <= '0;
      end else begin
         state_q  <= state_d;
         chunk_q  <= chunk_d;
         active_q <= active_d;
         start_q  <= start_d;
         base_q   <= base_d;
         abort_q  <= abort_d;
         busy_q   <= busy_d;
         found_q  <= found_d;
         exh_q    <= exh_d;
         fkey_q   <= fkey_d;
         fcore_q  <= fcore_d;
      end
   end

`ifdef KEYSEARCH_RR_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rr_q <= '0;
      else       rr_q <= rr_d;
   end
`endif

   assign core_start = start_q;
   assign core_base  = base_q;
   assign core_abort = abort_q;
   assign busy       = busy_q;
   assign found      = found_q;
   assign exhausted  = exh_q;
   assign found_key  = fkey_q;
   assign found_core = fcore_q;

endmodule

// File: tb/tb_keysearch_scheduler.sv
module tb_keysearch_scheduler;

   localparam int NC = 4;
   localparam int KB = 6;
   localparam int CL = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [NC-1:0]   core_start;
   logic [NC*KB-1:0] core_base;
   logic            core_abort;
   logic [NC-1:0]   core_done;
   logic [NC-1:0]   core_hit;
   logic [NC*KB-1:0] core_hit_key;
   logic            busy, found, exhausted;
   logic [KB-1:0]   found_key;
   logic [1:0]      found_core;

   keysearch_scheduler #(.NUM_CORES(NC), .KEY_BITS(KB), .CHUNK_LOG(CL)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .core_start   (core_start),
      .core_base    (core_base),
      .core_abort   (core_abort),
      .core_done    (core_done),
      .core_hit     (core_hit),
      .core_hit_key (core_hit_key),
      .busy         (busy),
      .found        (found),
      .exhausted    (exhausted),
      .found_key    (found_key),
      .found_core   (found_core)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic [3:0]  done;
      logic [3:0]  hit;
      logic [23:0] hkey;
      logic [3:0]  e_cs;
      logic [23:0] e_base;
      logic        e_ab;
      logic        e_busy;
      logic        e_fnd;
      logic        e_exh;
      logic [5:0]  e_key;
      logic [1:0]  e_core;
   } vec_t;

   localparam logic [23:0] BF = 24'hC20400;  // bases 30,20,10,00 on cores 3..0
   localparam logic [23:0] BE = 24'hC20430;  // core 0 relaunched at base 0x30

   vec_t tbl [39];
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Inputs driven here are sampled at the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input vec_t v);
      chk({tag, " core_start"}, 32'(core_start), 32'(v.e_cs));
      chk({tag, " core_base"},  32'(core_base),  32'(v.e_base));
      chk({tag, " core_abort"}, 32'(core_abort), 32'(v.e_ab));
      chk({tag, " busy"},       32'(busy),       32'(v.e_busy));
      chk({tag, " found"},      32'(found),      32'(v.e_fnd));
      chk({tag, " exhausted"},  32'(exhausted),  32'(v.e_exh));
      chk({tag, " found_key"},  32'(found_key),  32'(v.e_key));
      chk({tag, " found_core"}, 32'(found_core), 32'(v.e_core));
   endtask

   initial begin
      vec_t z;
      logic [3:0] dn;

      //        st done hit hkey          cs   base          ab busy fnd exh key    core
      // hit on core 2 after fill
      tbl[0]  = '{1'b1, 4'h0, 4'h0, 24'h0,      4'h0, 24'h000000, 0, 0, 0, 0, 6'h00, 2'd0};
      tbl[1]  = '{1'b0, 4'h0, 4'h0, 24'h0,      4'h0, 24'h000000, 0, 1, 0, 0, 6'h00, 2'd0};
      tbl[2]  = '{1'b0, 4'h0, 4'h0, 24'h0,      4'h1, 24'h000000, 0, 1, 0, 0, 6'h00, 2'd0};
      tbl[3]  = '{1'b0, 4'h0, 4'h0, 24'h0,      4'h2, 24'h000400, 0, 1, 0, 0, 6'h00, 2'd0};
      tbl[4]  = '{1'b0, 4'h0, 4'h0, 24'h0,      4'h4, 24'h020400, 0, 1, 0, 0, 6'h00, 2'd0};
      tbl[5]  = '{1'b0, 4'h0, 4'h4, 24'h02B000, 4'h8, BF,         0, 1, 0, 0, 6'h00, 2'd0};
      tbl[6]  = '{1'b0, 4'h0, 4'h0, 24'h0,      4'h0, BF,         1, 0, 1, 0, 6'h2B, 2'd2};
      // restart; idle-core hit ignored; dual hit on cores 1 and 3
      tbl[7]  = '{1'b1, 4'h0, 4'h0, 24'h0,      4'h0, BF,         1, 0, 1, 0, 6'h2B, 2'd2};
      tbl[8]  = '{1'b0, 4'h0, 4'h0, 24'h0,      4'h0, BF,         0, 1, 0, 0, 6'h00, 2'd0};
      tbl[9]  = '{1'b0, 4'h0, 4'h8, 24'hFC0000, 4'h1, BF,         0, 1, 0, 0, 6'h00, 2'd0};
      tbl[10] = '{1'b0, 4'h0, 4'h0, 24'h0,      4'h2, BF,         0, 1, 0, 0, 6'h00, 2'd0};
      tbl[11] = '{1'b0, 4'h0, 4'h0, 24'h0,      4'h4, BF,         0, 1, 0, 0, 6'h00, 2'd0};
      tbl[12] = '{1'b0, 4'h0, 4'hA, 24'hE80540, 4'h8, BF,         0, 1, 0, 0, 6'h00, 2'd0};
      tbl[13] = '{1'b0, 4'h0, 4'h0, 24'h0,      4'h0, BF,         1, 0, 1, 0, 6'h15, 2'd1};
      // hit suppresses a dispatch in the same cycle
      tbl[14] = '{1'b1, 4'h0, 4'h0, 24'h0,      4'h0, BF,         1, 0, 1, 0, 6'h15, 2'd1};
      tbl[15] = '{1'b0, 4'h0, 4'h0, 24'h0,      4'h0, BF,         0, 1, 0, 0, 6'h00, 2'd0};
      tbl[16] = '{1'b0, 4'h0, 4'h5, 24'h02F005, 4'h1, BF,         0, 1, 0, 0, 6'h00, 2'd0};
      tbl[17] = '{1'b0, 4'h0, 4'h0, 24'h0,      4'h0, BF,         1, 0, 1, 0, 6'h05, 2'd0};
      // done and hit together on the last chunks
      tbl[18] = '{1'b1, 4'h0, 4'h0, 24'h0,      4'h0, BF,         1, 0, 1, 0, 6'h05, 2'd0};
      tbl[19] = '{1'b0, 4'h0, 4'h0, 24'h0,      4'h0, BF,         0, 1, 0, 0, 6'h00, 2'd0};
      tbl[20] = '{1'b0, 4'h0, 4'h0, 24'h0,      4'h1, BF,         0, 1, 0, 0, 6'h00, 2'd0};
      tbl[21] = '{1'b0, 4'h0, 4'h0, 24'h0,      4'h2, BF,         0, 1, 0, 0, 6'h00, 2'd0};
      tbl[22] = '{1'b0, 4'h0, 4'h0, 24'h0,      4'h4, BF,         0, 1, 0, 0, 6'h00, 2'd0};
      tbl[23] = '{1'b0, 4'hC, 4'h0, 24'h0,      4'h8, BF,         0, 1, 0, 0, 6'h00, 2'd0};
      tbl[24] = '{1'b0, 4'h1, 4'h2, 24'h000700, 4'h0, BF,         0, 1, 0, 0, 6'h00, 2'd0};
      tbl[25] = '{1'b0, 4'h0, 4'h0, 24'h0,      4'h0, BF,         1, 0, 1, 0, 6'h1C, 2'd1};
      // done -> relaunch next cycle, then drain to exhausted
      tbl[26] = '{1'b1, 4'h0, 4'h0, 24'h0,      4'h0, BF,         1, 0, 1, 0, 6'h1C, 2'd1};
      tbl[27] = '{1'b0, 4'h0, 4'h0, 24'h0,      4'h0, BF,         0, 1, 0, 0, 6'h00, 2'd0};
      tbl[28] = '{1'b0, 4'h0, 4'h0, 24'h0,      4'h1, BF,         0, 1, 0, 0, 6'h00, 2'd0};
      tbl[29] = '{1'b0, 4'h0, 4'h0, 24'h0,      4'h2, BF,         0, 1, 0, 0, 6'h00, 2'd0};
      tbl[30] = '{1'b0, 4'h1, 4'h0, 24'h0,      4'h4, BF,         0, 1, 0, 0, 6'h00, 2'd0};
      tbl[31] = '{1'b0, 4'h2, 4'h0, 24'h0,      4'h1, BE,         0, 1, 0, 0, 6'h00, 2'd0};
      tbl[32] = '{1'b0, 4'h0, 4'h0, 24'h0,      4'h0, BE,         0, 1, 0, 0, 6'h00, 2'd0};
      tbl[33] = '{1'b0, 4'h8, 4'h0, 24'h0,      4'h0, BE,         0, 1, 0, 0, 6'h00, 2'd0};
      tbl[34] = '{1'b0, 4'h4, 4'h0, 24'h0,      4'h0, BE,         0, 1, 0, 0, 6'h00, 2'd0};
      tbl[35] = '{1'b0, 4'h1, 4'h0, 24'h0,      4'h0, BE,         0, 1, 0, 0, 6'h00, 2'd0};
      tbl[36] = '{1'b0, 4'h0, 4'h0, 24'h0,      4'h0, BE,         0, 0, 0, 1, 6'h00, 2'd0};
      tbl[37] = '{1'b1, 4'h0, 4'h0, 24'h0,      4'h0, BE,         0, 0, 0, 1, 6'h00, 2'd0};
      tbl[38] = '{1'b0, 4'h0, 4'h0, 24'h0,      4'h0, BE,         0, 1, 0, 0, 6'h00, 2'd0};

      reset        = 1'b1;
      start        = 1'b0;
      core_done    = '0;
      core_hit     = '0;
      core_hit_key = '0;

      z = '{1'b0, 4'h0, 4'h0, 24'h0, 4'h0, 24'h0, 0, 0, 0, 0, 6'h00, 2'd0};
      #12;
      chk_all("reset", z);
      @(negedge clk);
      reset = 1'b0;

      for (int k = 0; k < 39; k++) begin
         step();
         start        = tbl[k].st;
         core_done    = tbl[k].done;
         core_hit     = tbl[k].hit;
         core_hit_key = tbl[k].hkey;
         chk_all($sformatf("row%0d", k), tbl[k]);
      end

      // Each core reports done 20 cycles after its launch; four chunks only.
      for (int c = 0; c < 28; c++) begin
         step();
         dn = '0;
         for (int i = 0; i < NC; i++)
            if (c == i + 20) dn[i] = 1'b1;
         start        = 1'b0;
         core_done    = dn;
         core_hit     = '0;
         core_hit_key = '0;
         chk($sformatf("fill%0d core_start", c), 32'(core_start),
             (c < NC) ? 32'(1) << c : 32'd0);
         if (c < NC)
            chk($sformatf("fill%0d base", c), 32'(core_base[c*KB +: KB]), 32'(c * 16));
         chk($sformatf("fill%0d busy", c), 32'(busy), (c <= 23) ? 32'd1 : 32'd0);
         chk($sformatf("fill%0d exhausted", c), 32'(exhausted), (c >= 24) ? 32'd1 : 32'd0);
         chk($sformatf("fill%0d found", c), 32'(found), 32'd0);
      end

      // Asynchronous reset in the middle of a search.
      step();
      start     = 1'b1;
      core_done = '0;
      step();
      start = 1'b0;
      step();
      chk("pre_reset core_start", 32'(core_start), 32'h1);
      chk("pre_reset busy", 32'(busy), 32'h1);
      #2;
      reset = 1'b1;
      #1;
      chk_all("async_reset", z);
      #2;
      reset = 1'b0;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart busy", 32'(busy), 32'h1);
      step();
      chk("restart core_start", 32'(core_start), 32'h1);
      chk("restart base0", 32'(core_base[0 +: KB]), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/keysearch_scheduler.md
# keysearch_scheduler

Dispatches contiguous chunks of the RC4 key search space to `NUM_CORES` parallel arcfour decryption cores and stops all of them on the first successful decryption. Sits above the core array in the cracking top level: it owns the key-range counter, hands each idle core a base key, collects done/hit pulses, arbitrates simultaneous hits and reports the winning key.

## Interface
Parameters:
- `NUM_CORES`, 4: number of arcfour cores scheduled (1..16).
- `KEY_BITS`, 22: width of the searchable key value.
- `CHUNK_LOG`, 16: log2 of keys per chunk; `NUM_CHUNKS` = 2^(`KEY_BITS`-`CHUNK_LOG`); require `CHUNK_LOG` < `KEY_BITS`.

Ports:
- `clk` in 1: single clock; every register is on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: single-cycle pulse that begins a search.
- `core_start` out `NUM_CORES`: one-cycle pulse per core launching a chunk.
- `core_base` out `NUM_CORES*KEY_BITS`: base key of the chunk for each core; valid and held from the `core_start` pulse until the next dispatch to that core.
- `core_abort` out 1: level; orders all cores back to idle.
- `core_done` in `NUM_CORES`: one-cycle pulse; chunk exhausted with no hit.
- `core_hit` in `NUM_CORES`: one-cycle pulse; decryption succeeded.
- `core_hit_key` in `NUM_CORES*KEY_BITS`: key that succeeded; valid with `core_hit`.
- `busy` out 1: high in RUN and DRAIN.
- `found` out 1: level; high in FOUND.
- `exhausted` out 1: level; high in EXHAUSTED.
- `found_key` out `KEY_BITS`: captured winning key.
- `found_core` out clog2(`NUM_CORES`): index of the winning core.

## Operation
- States: IDLE, RUN, DRAIN, FOUND, EXHAUSTED.
- IDLE -> RUN on `start`. This clears the chunk counter, the idle vector (all cores idle), `found_key` and `found_core`.
- RUN dispatch:
  - Each cycle, at most one core is dispatched.
  - Eligible cores: idle, or pulsing `core_done` this cycle.
  - Chosen core gets `core_base` = chunk << `CHUNK_LOG` and `core_start`. The core is marked busy and the chunk counter increments.
- Chunk counter is `KEY_BITS`-`CHUNK_LOG`+1 bits wide and never wraps. When it reaches `NUM_CHUNKS`: RUN -> DRAIN.
- DRAIN -> EXHAUSTED when all cores are idle with no hit.
- Any `core_hit` in RUN or DRAIN:
  - Capture `found_key` and `found_core` from the selected hitting core.
  - Go to FOUND and assert `core_abort`. No further `core_start` is issued.
- Hit in the same cycle as a dispatch decision: the hit wins and the dispatch is suppressed.
- Hit in the same cycle as the final `core_done`: FOUND, not EXHAUSTED.
- Hits from more than one core in the same cycle: the lowest index wins.
- `core_done` or `core_hit` from a core already marked idle is ignored.
- FOUND and EXHAUSTED hold until `start`. Then go to RUN with a fresh search; `core_abort` drops the same cycle.
- `start` in RUN or DRAIN is ignored.

## Timing
- Reset values: state IDLE; every output 0 (`core_start`, `core_base`, `core_abort`, `busy`, `found`, `exhausted`, `found_key`, `found_core`).
- Reset asserted mid-search: outputs drop to 0 asynchronously. Cores see `core_abort`=0, so the top level resets them on the same `reset`.
- All outputs are registered.
- `start` in cycle t: `busy` high t+1; first `core_start` (core 0, base 0) in cycle t+2.
- `core_done` in cycle t: the same core can receive `core_start` in t+1.
- `core_hit` in cycle t: `found`, `found_key`, `found_core` and `core_abort` valid in t+1; `busy` low in t+1.
- Final core goes idle in cycle t: `exhausted` high in t+1.
- Fill time: with all cores idle, `NUM_CORES` dispatches take `NUM_CORES` consecutive cycles.

## Configuration
- `KEYSEARCH_RR_EN` defined:
  - Dispatch uses a round-robin pointer, advanced past the last dispatched core.
  - Simultaneous hits: the winner is the first hitting core at or after the pointer.
- Undefined: fixed priority for both, lowest index first. Saves the pointer register.

## Test plan
- `NUM_CORES`=4, `KEY_BITS`=6, `CHUNK_LOG`=4. `start`, then each core pulses `core_done` 20 cycles after its start -> bases 0x00, 0x10, 0x20, 0x30 on cores 0..3 in consecutive cycles. DRAIN follows, then `exhausted`=1 one cycle after the last done; `found`=0.
- Same setup; core 2 pulses `core_hit` with key 0x2B -> next cycle `found`=1, `found_key`=0x2B, `found_core`=2, `core_abort`=1; no further `core_start`.
- Cores 1 and 3 hit in the same cycle (keys 0x15, 0x3A), macro undefined -> `found_key`=0x15, `found_core`=1.
- Core 0 `core_done` and core 1 `core_hit` in the same cycle on the last chunk -> FOUND, `exhausted` stays 0.
- `reset` asserted mid-RUN between clock edges -> all outputs 0 immediately. A following `start` restarts at base 0.
- `KEYSEARCH_RR_EN` defined, 2 cores idle, `core_done` from core 0 and core 1 repeatedly -> dispatch alternates rather than always choosing core 0.
